tlb_op_unit: RTL and testbench

TLB_OP_UNIT -- requirements
Module: tlb_op_unit

---
 rtl/tlb_pkg.sv | 62 ++++++
 rtl/tlb_fill_idx_gen.sv | 33 +++
 rtl/tlb_op_unit.sv | 158 +++++++++++++++
 tb/tb_tlb_op_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared TLB op encodings, entry layout and constants
package tlb_pkg;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } tlb_state_e;

    localparam logic [5:0] PS_4K      = 6'd12;
    localparam logic [5:0] PS_4M      = 6'd22;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;
    localparam logic [4:0] INV_OP_MAX = 5'd6;

    // One page half of an entry, bit-for-bit the TLBELO CSR image
    typedef struct packed {
        logic [23:0] ppn;
        logic        rsvd;
        logic        g;
        logic [1:0]  mat;
        logic [1:0]  plv;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic        e;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    localparam int TLB_ENTRY_W = $bits(tlb_entry_t);

    // Fibonacci feedback masks for maximal-length LFSRs, shifting left
    function automatic logic [31:0] lfsr_taps(input int n);
        case (n)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            default: return 32'h0000_0003;
        endcase
    endfunction

endpackage

// File: rtl/tlb_fill_idx_gen.sv
// rtl/tlb_fill_idx_gen.sv - fill index source: counter, or LFSR when TLB_FILL_LFSR_EN is defined
module tlb_fill_idx_gen
    import tlb_pkg::*;
#(
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic [IW-1:0] idx
);

`ifdef TLB_FILL_LFSR_EN
    logic [IW-1:0] taps;
    assign taps = IW'(lfsr_taps(IW));

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= IW'(1);
        end else begin
            idx <= {idx[IW-2:0], ^(idx & taps)};
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else begin
            idx <= idx + IW'(1);
        end
    end
`endif

endmodule

// File: rtl/tlb_op_unit.sv
// rtl/tlb_op_unit.sv - sequences one TLB maintenance op (search/read/write/fill/invalidate) at a time
module tlb_op_unit
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    req_inv_op,
    input  logic [9:0]    req_asid,
    input  logic [31:0]   req_va,
    input  logic [IW-1:0] csr_index,
    input  logic          csr_ne,
    input  logic [5:0]    csr_ps,
    input  logic [18:0]   csr_vppn,
    input  logic [9:0]    csr_asid,
    input  logic [31:0]   csr_elo0,
    input  logic [31:0]   csr_elo1,
    input  logic [5:0]    csr_ecode,
    output logic [18:0]   s_vppn,
    output logic          s_va_bit12,
    output logic [9:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    output logic          we,
    output logic [IW-1:0] w_index,
    output tlb_entry_t    w_entry,
    output logic [IW-1:0] r_index,
    input  tlb_entry_t    r_entry,
    output logic          invtlb_valid,
    output logic [4:0]    invtlb_op,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [2:0]    resp_op,
    output logic          resp_found,
    output logic [IW-1:0] resp_index,
    output tlb_entry_t    resp_entry,
    output logic          resp_err
);

    tlb_state_e    state_q, state_d;
    logic [2:0]    op_q;
    logic [4:0]    inv_op_q;
    logic [9:0]    asid_q;
    logic [19:0]   va_q;
    logic [IW-1:0] fill_q;
    logic [IW-1:0] fill_idx;
    logic          exec;
    logic          inv_bad;
    logic          op_reserved;
    logic          unused_va;

    assign unused_va = ^req_va[11:0];

    tlb_fill_idx_gen #(.IW(IW)) u_fill_idx (
        .clk   (clk),
        .reset (reset),
        .idx   (fill_idx)
    );

    assign exec        = (state_q == ST_EXEC);
    assign op_reserved = (op_q > OP_INV);
    assign inv_bad     = (op_q == OP_INV) && (inv_op_q > INV_OP_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pulses are gated by reset so a request dropped mid-EXEC never touches the TLB
    always_comb begin
        req_ready    = (state_q == ST_IDLE);
        resp_valid   = (state_q == ST_RESP);
        we           = exec && !reset && ((op_q == OP_WR) || (op_q == OP_FILL));
        invtlb_valid = exec && !reset && (op_q == OP_INV) && !inv_bad;
        invtlb_op    = inv_op_q;
        w_index      = (op_q == OP_FILL) ? fill_q : csr_index;
        r_index      = csr_index;
        s_vppn       = '0;
        s_asid       = '0;
        s_va_bit12   = 1'b0;
        if (exec && (op_q == OP_SRCH)) begin
            s_vppn = csr_vppn;
            s_asid = csr_asid;
        end else if (exec && (op_q == OP_INV) && !inv_bad) begin
            s_vppn     = va_q[19:1];
            s_asid     = asid_q;
            s_va_bit12 = va_q[0];
        end
    end

    always_comb begin
        w_entry      = '0;
        w_entry.vppn = csr_vppn;
        w_entry.ps   = csr_ps;
        w_entry.asid = csr_asid;
        w_entry.p0   = tlb_page_t'(csr_elo0);
        w_entry.p1   = tlb_page_t'(csr_elo1);
        w_entry.g    = w_entry.p0.g & w_entry.p1.g;
        w_entry.e    = (csr_ecode == ECODE_TLBR) ? 1'b1 : ~csr_ne;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            inv_op_q <= '0;
            asid_q   <= '0;
            va_q     <= '0;
            fill_q   <= '0;
        end else if (req_valid && req_ready) begin
            op_q     <= req_op;
            inv_op_q <= req_inv_op;
            asid_q   <= req_asid;
            va_q     <= req_va[31:12];
            fill_q   <= fill_idx;
        end
    end

    // Response fields load only in EXEC, so they stay frozen through RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_op    <= '0;
            resp_found <= 1'b0;
            resp_index <= '0;
            resp_entry <= '0;
            resp_err   <= 1'b0;
        end else if (exec) begin
            resp_op    <= op_q;
            resp_found <= (op_q == OP_SRCH) && s_found;
            resp_err   <= op_reserved || inv_bad;
            resp_entry <= ((op_q == OP_RD) && r_entry.e) ? r_entry : '0;
            case (op_q)
                OP_SRCH:      resp_index <= s_index;
                OP_RD, OP_WR: resp_index <= csr_index;
                OP_FILL:      resp_index <= fill_q;
                default:      resp_index <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_unit.sv
// tb/tb_tlb_op_unit.sv - scoreboard bench for tlb_op_unit
module tb_tlb_op_unit;
    import tlb_pkg::*;

    localparam int TLBNUM = 16;
    localparam int IW     = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [2:0]    req_op;
    logic [4:0]    req_inv_op;
    logic [9:0]    req_asid;
    logic [31:0]   req_va;
    logic [IW-1:0] csr_index;
    logic          csr_ne;
    logic [5:0]    csr_ps;
    logic [18:0]   csr_vppn;
    logic [9:0]    csr_asid;
    logic [31:0]   csr_elo0, csr_elo1;
    logic [5:0]    csr_ecode;
    logic [18:0]   s_vppn;
    logic          s_va_bit12;
    logic [9:0]    s_asid;
    logic          s_found;
    logic [IW-1:0] s_index;
    logic          we;
    logic [IW-1:0] w_index;
    tlb_entry_t    w_entry;
    logic [IW-1:0] r_index;
    tlb_entry_t    r_entry;
    logic          invtlb_valid;
    logic [4:0]    invtlb_op;
    logic          resp_valid, resp_ready;
    logic [2:0]    resp_op;
    logic          resp_found;
    logic [IW-1:0] resp_index;
    tlb_entry_t    resp_entry;
    logic          resp_err;

    tlb_op_unit #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_inv_op(req_inv_op), .req_asid(req_asid), .req_va(req_va),
        .csr_index(csr_index), .csr_ne(csr_ne), .csr_ps(csr_ps), .csr_vppn(csr_vppn),
        .csr_asid(csr_asid), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_ecode(csr_ecode),
        .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
        .s_found(s_found), .s_index(s_index),
        .we(we), .w_index(w_index), .w_entry(w_entry),
        .r_index(r_index), .r_entry(r_entry),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
        .resp_found(resp_found), .resp_index(resp_index), .resp_entry(resp_entry),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    op;
        logic          found;
        logic [IW-1:0] idx;
        tlb_entry_t    entry;
        logic          err;
    } resp_t;

    typedef struct {
        logic          is_inv;
        logic [IW-1:0] idx;
        logic          e;
        logic          g;
        logic [18:0]   vppn;
        logic [4:0]    inv_op;
        logic [9:0]    asid;
        logic          bit12;
    } pulse_t;

    resp_t      resp_q[$];
    pulse_t     pulse_q[$];
    int         acc_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] cnt_m = '0;
    tlb_entry_t entry_a, entry_b;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Tiny TLB: entry 5 holds vppn 0x1234 / asid 3; entries 9 and 4 are readable
    always_comb begin
        s_found = (s_vppn == 19'h01234) && (s_asid == 10'd3);
        s_index = s_found ? 4'd5 : 4'd0;
        if (r_index == 4'd9)      r_entry = entry_a;
        else if (r_index == 4'd4) r_entry = entry_b;
        else                      r_entry = '0;
    end

    always @(posedge clk) begin
        if (reset) begin
            acc_q.delete();
            cnt_m <= '0;
        end else begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            cnt_m <= cnt_m + 4'd1;
        end
        cyc <= cyc + 1;
    end

    resp_t cur;
    logic  prev_v = 1'b0;
    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (!prev_v) begin
                if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
                else cur = resp_q.pop_front();
                if (acc_q.size() == 0) chk("accept_missing", 1, 0);
                else chk("resp_latency", 128'(cyc - acc_q.pop_front()), 2);
            end
            chk("resp_op", resp_op, cur.op);
            chk("resp_found", resp_found, cur.found);
            chk("resp_index", resp_index, cur.idx);
            chk("resp_entry", resp_entry, cur.entry);
            chk("resp_err", resp_err, cur.err);
            if (!resp_ready) chk("req_ready_during_resp", req_ready, 0);
        end
        prev_v = resp_valid && !reset;
    end

    always @(negedge clk) begin
        pulse_t p;
        if (we && invtlb_valid) chk("we_and_invtlb", 1, 0);
        if (!invtlb_valid && s_va_bit12) chk("s_va_bit12_idle", 1, 0);
        if (we) begin
            if (pulse_q.size() == 0) chk("we_unexpected", 1, 0);
            else begin
                p = pulse_q.pop_front();
                chk("we_kind", p.is_inv, 0);
                chk("w_index", w_index, p.idx);
                chk("w_entry_e", w_entry.e, p.e);
                chk("w_entry_g", w_entry.g, p.g);
                chk("w_entry_vppn", w_entry.vppn, p.vppn);
            end
        end
        if (invtlb_valid) begin
            if (pulse_q.size() == 0) chk("invtlb_unexpected", 1, 0);
            else begin
                p = pulse_q.pop_front();
                chk("inv_kind", p.is_inv, 1);
                chk("invtlb_op", invtlb_op, p.inv_op);
                chk("inv_s_vppn", s_vppn, p.vppn);
                chk("inv_s_asid", s_asid, p.asid);
                chk("inv_s_va_bit12", s_va_bit12, p.bit12);
            end
        end
    end

    task automatic exp_resp(input logic [2:0] op, input logic found, input logic [IW-1:0] idx,
                            input tlb_entry_t entry, input logic err);
        resp_t r;
        r.op = op; r.found = found; r.idx = idx; r.entry = entry; r.err = err;
        resp_q.push_back(r);
    endtask

    task automatic exp_we(input logic [IW-1:0] idx, input logic e, input logic g, input logic [18:0] vppn);
        pulse_t p;
        p = '{is_inv: 1'b0, idx: idx, e: e, g: g, vppn: vppn, inv_op: 5'd0, asid: 10'd0, bit12: 1'b0};
        pulse_q.push_back(p);
    endtask

    task automatic exp_inv(input logic [4:0] iop, input logic [18:0] vppn, input logic [9:0] asid, input logic bit12);
        pulse_t p;
        p = '{is_inv: 1'b1, idx: '0, e: 1'b0, g: 1'b0, vppn: vppn, inv_op: iop, asid: asid, bit12: bit12};
        pulse_q.push_back(p);
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] asid, input logic [31:0] va);
        int n = 0;
        req_op = op; req_inv_op = iop; req_asid = asid; req_va = va;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        if (!req_ready) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        entry_a      = '0;
        entry_a.vppn = 19'h00111;
        entry_a.ps   = PS_4K;
        entry_a.asid = 10'd4;
        entry_a.e    = 1'b1;
        entry_a.p0   = tlb_page_t'(32'h0001_2313);
        entry_a.p1   = tlb_page_t'(32'h0004_5617);
        entry_b      = entry_a;
        entry_b.e    = 1'b0;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_inv_op = '0; req_asid = '0; req_va = '0;
        csr_index = '0; csr_ne = 1'b0; csr_ps = PS_4K; csr_vppn = '0; csr_asid = '0;
        csr_elo0 = '0; csr_elo1 = '0; csr_ecode = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_we", we, 0);
        chk("rst_invtlb_valid", invtlb_valid, 0);
        chk("rst_resp_index", resp_index, 0);
        chk("rst_resp_err", resp_err, 0);

        csr_vppn = 19'h01234; csr_asid = 10'd3;
        exp_resp(OP_SRCH, 1'b1, 4'd5, '0, 1'b0);
        send(OP_SRCH, 5'd0, 10'd0, 32'd0); wait_idle();
        csr_asid = 10'd4;
        exp_resp(OP_SRCH, 1'b0, 4'd0, '0, 1'b0);
        send(OP_SRCH, 5'd0, 10'd0, 32'd0); wait_idle();

        csr_index = 4'd9;
        exp_resp(OP_RD, 1'b0, 4'd9, entry_a, 1'b0);
        send(OP_RD, 5'd0, 10'd0, 32'd0); wait_idle();
        csr_index = 4'd4;
        exp_resp(OP_RD, 1'b0, 4'd4, '0, 1'b0);
        send(OP_RD, 5'd0, 10'd0, 32'd0); wait_idle();

        csr_index = 4'd7; csr_ne = 1'b1; csr_ecode = 6'h3F;
        csr_elo0 = 32'h0000_0041; csr_elo1 = 32'h0000_0001;
        exp_we(4'd7, 1'b1, 1'b0, 19'h01234);
        exp_resp(OP_WR, 1'b0, 4'd7, '0, 1'b0);
        send(OP_WR, 5'd0, 10'd0, 32'd0); wait_idle();
        csr_index = 4'd3; csr_ecode = 6'h00; csr_elo1 = 32'h0000_0041;
        exp_we(4'd3, 1'b0, 1'b1, 19'h01234);
        exp_resp(OP_WR, 1'b0, 4'd3, '0, 1'b0);
        send(OP_WR, 5'd0, 10'd0, 32'd0); wait_idle();

        csr_ne = 1'b0; csr_vppn = 19'h00ABC;
        while (cnt_m != 4'd15) @(negedge clk);
        exp_we(4'd15, 1'b1, 1'b1, 19'h00ABC);
        exp_resp(OP_FILL, 1'b0, 4'd15, '0, 1'b0);
        send(OP_FILL, 5'd0, 10'd0, 32'd0); wait_idle();
        exp_we(4'd2, 1'b1, 1'b1, 19'h00ABC);
        exp_resp(OP_FILL, 1'b0, 4'd2, '0, 1'b0);
        send(OP_FILL, 5'd0, 10'd0, 32'd0); wait_idle();

        exp_inv(5'd5, 19'h55E6F, 10'h02A, 1'b1);
        exp_resp(OP_INV, 1'b0, 4'd0, '0, 1'b0);
        send(OP_INV, 5'd5, 10'h02A, 32'hABCD_F000); wait_idle();
        exp_resp(OP_INV, 1'b0, 4'd0, '0, 1'b1);
        send(OP_INV, 5'd9, 10'h02A, 32'hABCD_F000); wait_idle();

        exp_resp(3'd6, 1'b0, 4'd0, '0, 1'b1);
        send(3'd6, 5'd0, 10'd0, 32'd0); wait_idle();
        exp_resp(3'd7, 1'b0, 4'd0, '0, 1'b1);
        send(3'd7, 5'd0, 10'd0, 32'd0); wait_idle();

        // Backpressure: response must hold for four cycles with resp_ready low
        csr_vppn = 19'h01234; csr_asid = 10'd3; resp_ready = 1'b0;
        exp_resp(OP_SRCH, 1'b1, 4'd5, '0, 1'b0);
        send(OP_SRCH, 5'd0, 10'd0, 32'd0);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!resp_valid && n < 20);
            if (!resp_valid) chk("hold_resp_timeout", 0, 1);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_idle();

        // Reset while the write is in EXEC: no pulse, no response
        csr_index = 4'd6;
        send(OP_WR, 5'd0, 10'd0, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", req_ready, 1);
        chk("post_reset_resp_valid", resp_valid, 0);
        @(negedge clk);
        chk("post_reset_resp_valid2", resp_valid, 0);

        repeat (5) @(negedge clk);
        chk("resp_q_drained", 128'(resp_q.size()), 0);
        chk("pulse_q_drained", 128'(pulse_q.size()), 0);
        chk("accept_q_drained", 128'(acc_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
